// File: rtl/grid_pkg.sv
// Shared definitions for the stencil sequencer: field layout of grid points and core results,
// FSM state encoding and window source selection.
package grid_pkg;

    localparam int DW = 64;

    // Word index of each field inside in_data ({r,K,pi_m,alpha,phi,psi}, r in MSBs)
    localparam int F_PSI   = 0;
    localparam int F_PHI   = 1;
    localparam int F_ALPHA = 2;
    localparam int F_PI_M  = 3;
    localparam int F_K     = 4;
    localparam int F_R     = 5;

    // Word index of each derivative inside core_res ({alpha_t,K_t,phi_t,pi_m_t,psi_t})
    localparam int R_PSI_T   = 0;
    localparam int R_PI_M_T  = 1;
    localparam int R_PHI_T   = 2;
    localparam int R_K_T     = 3;
    localparam int R_ALPHA_T = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_ISSUE,
        S_WAIT,
        S_OUT,
        S_ADV,
        S_DONE,
        S_REJ
    } state_t;

    typedef enum logic {
        SRC_INPUT = 1'b0,
        SRC_EDGE  = 1'b1
    } src_sel_t;

endpackage

// File: rtl/stencil_window.sv
// Five-deep grid-point shift register (w4 newest) with the inner-boundary reflection mux
// that forms the i-2..i+2 stencils and the centre fields.
module stencil_window
    import grid_pkg::*;
#(
    parameter int DW = grid_pkg::DW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              shift,
    input  src_sel_t          src_sel,
    input  logic              i_is0,
    input  logic              i_is1,
    input  logic [6*DW-1:0]   point,
    output logic [DW-1:0]     c_r,
    output logic [DW-1:0]     c_K,
    output logic [DW-1:0]     c_pi_m,
    output logic [5*DW-1:0]   c_alpha,
    output logic [5*DW-1:0]   c_phi,
    output logic [5*DW-1:0]   c_psi
);

    logic [6*DW-1:0] w [5];
    logic [6*DW-1:0] src;
    logic [6*DW-1:0] lo1;
    logic [6*DW-1:0] lo0;

    function automatic logic [DW-1:0] fld(input logic [6*DW-1:0] p, input int f);
        return p[f*DW +: DW];
    endfunction

    function automatic logic [5*DW-1:0] pack5(input logic [6*DW-1:0] a4, input logic [6*DW-1:0] a3,
                                              input logic [6*DW-1:0] a2, input logic [6*DW-1:0] a1,
                                              input logic [6*DW-1:0] a0, input int f);
        return {fld(a4, f), fld(a3, f), fld(a2, f), fld(a1, f), fld(a0, f)};
    endfunction

    // Edge copy repeats the newest point, giving p(n)=p(n+1)=p(n-1) at the outer boundary
    assign src = (src_sel == SRC_EDGE) ? w[4] : point;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 5; k++) w[k] <= '0;
        end else if (shift) begin
            for (int k = 0; k < 4; k++) w[k] <= w[k+1];
            w[4] <= src;
        end
    end

    always_comb begin
        lo1 = w[1];
        lo0 = w[0];
        if (i_is0) begin
            lo1 = w[3];
            lo0 = w[4];
        end else if (i_is1) begin
            lo0 = w[2];
        end
        c_alpha = pack5(w[4], w[3], w[2], lo1, lo0, F_ALPHA);
        c_phi   = pack5(w[4], w[3], w[2], lo1, lo0, F_PHI);
        c_psi   = pack5(w[4], w[3], w[2], lo1, lo0, F_PSI);
        c_r     = fld(w[2], F_R);
        c_K     = fld(w[2], F_K);
        c_pi_m  = fld(w[2], F_PI_M);
    end

endmodule

// File: rtl/stencil_sequencer.sv
// Feeds grid points through a 5-point window to the calculation core, one point in flight,
// and returns one result per point in order. Optional watchdog: define STENCIL_TMO_EN.
module stencil_sequencer
    import grid_pkg::*;
#(
    parameter int DW      = 64,
    parameter int IDX_W   = 16,
    parameter int TMO_CYC = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    input  logic [IDX_W-1:0]   n_points,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [6*DW-1:0]    in_data,
    output logic               core_start,
    output logic [DW-1:0]      c_r,
    output logic [DW-1:0]      c_K,
    output logic [DW-1:0]      c_pi_m,
    output logic [5*DW-1:0]    c_alpha,
    output logic [5*DW-1:0]    c_phi,
    output logic [5*DW-1:0]    c_psi,
    input  logic               core_finish,
    input  logic [5*DW-1:0]    core_res,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [5*DW-1:0]    out_data,
    output logic [IDX_W-1:0]   out_idx,
    output logic               busy,
    output logic               done,
    output logic               tmo_err
);

    state_t           state, state_nx;
    src_sel_t         src_sel;
    logic             shift;
    logic             tmo_hit;
    logic             accept;
    logic [IDX_W-1:0] n_lat;
    logic [IDX_W-1:0] i_cnt;
    logic [IDX_W-1:0] rx_cnt;

    assign accept = (state == S_IDLE) && run && (n_points >= IDX_W'(3));

    stencil_window #(.DW(DW)) u_window (
        .clk     (clk),
        .rst_n   (rst_n),
        .shift   (shift),
        .src_sel (src_sel),
        .i_is0   (i_cnt == '0),
        .i_is1   (i_cnt == IDX_W'(1)),
        .point   (in_data),
        .c_r     (c_r),
        .c_K     (c_K),
        .c_pi_m  (c_pi_m),
        .c_alpha (c_alpha),
        .c_phi   (c_phi),
        .c_psi   (c_psi)
    );

`ifdef STENCIL_TMO_EN
    localparam int WC_W = $clog2(TMO_CYC + 1);
    logic [WC_W-1:0] wcnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt    <= '0;
            tmo_err <= 1'b0;
        end else begin
            if (state == S_ISSUE)     wcnt <= '0;
            else if (state == S_WAIT) wcnt <= wcnt + WC_W'(1);
            if (accept)               tmo_err <= 1'b0;
            else if (tmo_hit)         tmo_err <= 1'b1;
        end
    end

    // Cycle TMO_CYC after core_start with no finish: give up on this point
    assign tmo_hit = (state == S_WAIT) && !core_finish && (wcnt == WC_W'(TMO_CYC - 1));
`else
    assign tmo_hit = 1'b0;
    assign tmo_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            n_lat    <= '0;
            i_cnt    <= '0;
            rx_cnt   <= '0;
            out_data <= '0;
            out_idx  <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                n_lat  <= n_points;
                i_cnt  <= '0;
                rx_cnt <= '0;
            end else begin
                if (in_valid && in_ready)       rx_cnt <= rx_cnt + IDX_W'(1);
                if ((state == S_ADV) && shift)  i_cnt  <= i_cnt + IDX_W'(1);
            end
            if ((state == S_WAIT) && (core_finish || tmo_hit)) begin
                out_data <= core_finish ? core_res : '0;
                out_idx  <= i_cnt;
            end
        end
    end

    always_comb begin
        state_nx   = state;
        in_ready   = 1'b0;
        core_start = 1'b0;
        out_valid  = 1'b0;
        done       = 1'b0;
        shift      = 1'b0;
        src_sel    = SRC_INPUT;
        case (state)
            S_IDLE:  if (run) state_nx = (n_points >= IDX_W'(3)) ? S_FILL : S_REJ;
            S_REJ:   state_nx = S_DONE;
            S_FILL: begin
                in_ready = 1'b1;
                shift    = in_valid;
                if (in_valid && (rx_cnt == IDX_W'(2))) state_nx = S_ISSUE;
            end
            S_ISSUE: begin
                core_start = 1'b1;
                state_nx   = S_WAIT;
            end
            S_WAIT:  if (core_finish || tmo_hit) state_nx = S_OUT;
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = (i_cnt == n_lat - IDX_W'(1)) ? S_DONE : S_ADV;
            end
            S_ADV: begin
                if (rx_cnt < n_lat) begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        shift    = 1'b1;
                        state_nx = S_ISSUE;
                    end
                end else begin
                    src_sel  = SRC_EDGE;
                    shift    = 1'b1;
                    state_nx = S_ISSUE;
                end
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_stencil_sequencer.sv
// Directed bench for stencil_sequencer: grid source, latency-configurable core model and
// result sink, with expected stencils and results computed from the bench's own point table.
module tb_stencil_sequencer;

    localparam int DW    = 64;
    localparam int IDX_W = 16;
`ifdef STENCIL_TMO_EN
    localparam int TMO = 16;
`else
    localparam int TMO = 1024;
`endif

    logic               clk = 1'b0;
    logic               rst_n;
    logic               run;
    logic [IDX_W-1:0]   n_points;
    logic               in_valid;
    logic               in_ready;
    logic [6*DW-1:0]    in_data;
    logic               core_start;
    logic [DW-1:0]      c_r, c_K, c_pi_m;
    logic [5*DW-1:0]    c_alpha, c_phi, c_psi;
    logic               core_finish;
    logic [5*DW-1:0]    core_res;
    logic               out_valid;
    logic               out_ready;
    logic [5*DW-1:0]    out_data;
    logic [IDX_W-1:0]   out_idx;
    logic               busy, done, tmo_err;

    stencil_sequencer #(.DW(DW), .IDX_W(IDX_W), .TMO_CYC(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .n_points(n_points),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .core_start(core_start), .c_r(c_r), .c_K(c_K), .c_pi_m(c_pi_m),
        .c_alpha(c_alpha), .c_phi(c_phi), .c_psi(c_psi),
        .core_finish(core_finish), .core_res(core_res),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
        .busy(busy), .done(done), .tmo_err(tmo_err)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;
    logic [6*DW-1:0] pts [16];
    logic [5*DW-1:0] stn_alpha [16];
    int n_cur, lat, gap, rnd_rdy, hang_idx, frame_id;
    int starts, exp_idx, src_ptr, src_on;
    int done_cnt, done_cyc, run_cyc, cyc, start_seen, inrdy_seen, busy_seen;

    task automatic check_val(input string tag, input logic [6*DW-1:0] got, input logic [6*DW-1:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6*DW-1:0] mk_point(input int k);
        return {64'(300 + k), 64'(400 + k), 64'(500 + k), 64'(k + 1), 64'(100 + k), 64'(200 + k)};
    endfunction

    // Stencil word k holds p(i-2+k), reflected evenly at 0 and clamped to p(n-1) past the end
    function automatic logic [5*DW-1:0] exp_stencil(input int f, input int i, input int n);
        logic [5*DW-1:0] s;
        int j;
        for (int k = 0; k < 5; k++) begin
            j = i - 2 + k;
            if (j < 0) j = -j;
            if (j > n - 1) j = n - 1;
            s[k*DW +: DW] = pts[j][f*DW +: DW];
        end
        return s;
    endfunction

    function automatic logic [5*DW-1:0] res_of(input int i);
        logic [5*DW-1:0] r;
        for (int k = 0; k < 5; k++) r[k*DW +: DW] = {16'hC0DE, 16'(frame_id), 16'(i), 16'(k)};
        return r;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin : monitor
        @(negedge clk);
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (in_ready)   inrdy_seen++;
        if (core_start) start_seen++;
        if (busy)       busy_seen++;
    end

    initial begin : source
        logic fire;
        int gap_cnt;
        in_valid = 1'b0;
        in_data  = '0;
        gap_cnt  = 0;
        forever begin
            @(negedge clk);
            fire = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (fire) begin
                src_ptr++;
                gap_cnt = gap;
            end
            if (src_on == 0) gap_cnt = 0;
            if (src_on != 0 && src_ptr < 16 && gap_cnt == 0) begin
                in_valid = 1'b1;
                in_data  = pts[src_ptr];
            end else begin
                in_valid = 1'b0;
                if (gap_cnt > 0) gap_cnt--;
            end
        end
    end

    initial begin : core
        int i;
        core_finish = 1'b0;
        core_res    = '0;
        forever begin
            @(negedge clk);
            if (core_start) begin
                i = starts;
                starts++;
                stn_alpha[i & 15] = c_alpha;
                check_val("stencil_alpha", c_alpha, exp_stencil(2, i, n_cur));
                check_val("stencil_phi",   c_phi,   exp_stencil(1, i, n_cur));
                check_val("stencil_psi",   c_psi,   exp_stencil(0, i, n_cur));
                check_val("centre_r",      c_r,     pts[i & 15][5*DW +: DW]);
                check_val("centre_K",      c_K,     pts[i & 15][4*DW +: DW]);
                check_val("centre_pi_m",   c_pi_m,  pts[i & 15][3*DW +: DW]);
                @(negedge clk);
                check_val("start_pulse", core_start, 0);
                if (i != hang_idx) begin
                    repeat (lat - 1) @(negedge clk);
                    core_finish = 1'b1;
                    core_res    = res_of(i);
                    @(negedge clk);
                    core_finish = 1'b0;
                    core_res    = '0;
                end
            end
        end
    end

    initial begin : sink
        logic held;
        logic [5*DW-1:0] held_data;
        held = 1'b0;
        held_data = '0;
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (out_valid && held) check_val("out_stable", out_data, held_data);
            if (out_valid && out_ready) begin
                check_val("out_idx", out_idx, exp_idx);
                check_val("out_data", out_data, (exp_idx == hang_idx) ? '0 : res_of(exp_idx));
                exp_idx++;
            end
            held = out_valid && !out_ready;
            held_data = out_data;
            @(posedge clk);
            #1;
            out_ready = (rnd_rdy != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "bench timeout");
    end

    task automatic start_frame(input int n, input int l, input int g, input int rr);
        @(negedge clk);
        src_on = 0;
        @(negedge clk);
        @(negedge clk);
        frame_id++;
        n_cur = n; lat = l; gap = g; rnd_rdy = rr;
        starts = 0; exp_idx = 0; src_ptr = 0;
        done_cnt = 0; start_seen = 0; inrdy_seen = 0; busy_seen = 0;
        src_on = 1;
        @(posedge clk);
        #1;
        run = 1'b1;
        n_points = IDX_W'(n);
        run_cyc = cyc;
        @(posedge clk);
        #1;
        run = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int c;
        c = 0;
        while (done_cnt == 0 && c < budget) begin
            @(negedge clk);
            c++;
        end
        check_val("done_seen", 1'(done_cnt != 0), 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic end_checks(input int n);
        check_val("results_out", exp_idx, n);
        check_val("core_starts", starts, n);
        check_val("points_taken", src_ptr, n);
        check_val("done_pulses", done_cnt, 1);
        check_val("busy_after", busy, 0);
        check_val("busy_during", 1'(busy_seen > 0), 1);
    endtask

    initial begin
        int c;
        rst_n = 1'b0; run = 1'b0; n_points = '0;
        hang_idx = -1; lat = 3; gap = 0; rnd_rdy = 0; src_on = 0; frame_id = 0; n_cur = 3;
        starts = 0; exp_idx = 0; src_ptr = 0; cyc = 0;
        done_cnt = 0; start_seen = 0; inrdy_seen = 0; busy_seen = 0;
        for (int k = 0; k < 16; k++) pts[k] = mk_point(k);
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_in_ready", in_ready, 0);
        check_val("rst_core_start", core_start, 0);
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_tmo_err", tmo_err, 0);
        check_val("rst_out_data", out_data, 0);
        check_val("rst_out_idx", out_idx, 0);
        check_val("rst_c_alpha", c_alpha, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Minimum frame with hand-computed reflected/clamped stencils
        start_frame(3, 3, 0, 0);
        wait_done(2000);
        end_checks(3);
        check_val("n3_i0_alpha", stn_alpha[0], {64'd3, 64'd2, 64'd1, 64'd2, 64'd3});
        check_val("n3_i1_alpha", stn_alpha[1], {64'd3, 64'd3, 64'd2, 64'd1, 64'd2});
        check_val("n3_i2_alpha", stn_alpha[2], {64'd3, 64'd3, 64'd3, 64'd2, 64'd1});

        // Ramp with slow core and a randomly stalling consumer
        start_frame(8, 7, 0, 1);
        wait_done(4000);
        end_checks(8);

        // Input gaps that stall the window advance
        start_frame(8, 1, 4, 0);
        wait_done(4000);
        end_checks(8);

        // Too-short frame is rejected
        start_frame(2, 3, 0, 0);
        wait_done(100);
        check_val("rej_starts", start_seen, 0);
        check_val("rej_in_ready", inrdy_seen, 0);
        check_val("rej_done_lat", done_cyc - run_cyc, 2);
        check_val("rej_results", exp_idx, 0);
        check_val("rej_done_pulses", done_cnt, 1);

        // Reset while the core is working on i=4
        start_frame(8, 7, 0, 0);
        c = 0;
        while (starts < 5 && c < 2000) begin
            @(negedge clk);
            c++;
        end
        check_val("reach_i4", starts, 5);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check_val("mid_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check_val("mrst_in_ready", in_ready, 0);
        check_val("mrst_core_start", core_start, 0);
        check_val("mrst_out_valid", out_valid, 0);
        check_val("mrst_busy", busy, 0);
        check_val("mrst_out_data", out_data, 0);
        check_val("mrst_out_idx", out_idx, 0);
        check_val("mrst_c_alpha", c_alpha, 0);
        check_val("mrst_c_r", c_r, 0);
        src_on = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check_val("mrst_no_done", done_cnt, 0);
        start_frame(5, 3, 0, 1);
        wait_done(2000);
        end_checks(5);

`ifdef STENCIL_TMO_EN
        // Core never answers point 1: watchdog substitutes a zero result
        hang_idx = 1;
        start_frame(4, 3, 0, 0);
        wait_done(2000);
        end_checks(4);
        check_val("tmo_err_set", tmo_err, 1);
        hang_idx = -1;
        start_frame(3, 3, 0, 0);
        check_val("tmo_err_clr", tmo_err, 0);
        wait_done(2000);
        end_checks(3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
